// File: rtl/frac_lut_cfg_if.sv
// Configuration bus for frac_lut_cfg: start/valid/ready loader handshake plus status.
// FRAC_LUT_CFG_READBACK_EN adds the word readback channel.
interface frac_lut_cfg_if #(
  parameter int CFG_W = 8
) ();
  logic             cfg_start;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
`ifdef FRAC_LUT_CFG_READBACK_EN
  logic             cfg_rd_req;
  logic [CFG_W-1:0] cfg_rd_data;
  logic             cfg_rd_valid;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_rd_req,
    input  cfg_ready, cfg_done, cfg_err, cfg_rd_data, cfg_rd_valid
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_rd_req,
    output cfg_ready, cfg_done, cfg_err, cfg_rd_data, cfg_rd_valid
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, cfg_done, cfg_err
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, cfg_done, cfg_err
  );
`endif
endinterface

// File: rtl/frac_lut_cfg.sv
// K-input fracturable LUT with word-serial configuration loader; outputs gated until loaded.
// FRAC_LUT_CFG_READBACK_EN builds the word readback path on the cfg interface.
//
// state  | meaning
// S_IDLE | no configuration since reset, LUT outputs held at 0
// S_LOAD | accepting config words, cfg_ready high
// S_DONE | image complete, LUT live
module frac_lut_cfg #(
  parameter int K     = 6,
  parameter int CFG_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  frac_lut_cfg_if.slave cfg,
  input  logic [K-1:0]  in,
  output logic [3:0]    lut_lo_out,
  output logic [1:0]    lut_mid_out,
  output logic          lut_full_out
);

  localparam int N_T       = 2**K;
  localparam int N_CFG     = N_T + 2;
  localparam int N_WORDS   = (N_CFG + CFG_W - 1) / CFG_W;
  localparam int CNT_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LAST_BITS = N_CFG - (N_WORDS - 1) * CFG_W;
  localparam logic [CFG_W-1:0] LAST_MASK = {CFG_W{1'b1}} >> (CFG_W - LAST_BITS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CFG_W-1:0] r_words [N_WORDS];
  logic             r_ready;
  logic             r_done;
  logic             r_err;
`ifdef FRAC_LUT_CFG_READBACK_EN
  logic [CNT_W-1:0] r_rd_idx;
  logic [CFG_W-1:0] r_rd_data;
  logic             r_rd_valid;
`endif

  logic             w_accept;
  logic             w_last;
  logic [CFG_W-1:0] w_wr_data;

  assign w_accept  = cfg.cfg_valid & r_ready;
  assign w_last    = (r_cnt == CNT_W'(N_WORDS - 1));
  // Padding bits of the final word are stored as 0 so readback returns them as 0.
  assign w_wr_data = w_last ? (cfg.cfg_data & LAST_MASK) : cfg.cfg_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int w = 0; w < N_WORDS; w++) r_words[w] <= '0;
`ifdef FRAC_LUT_CFG_READBACK_EN
      r_rd_idx   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
`endif
    end else begin
`ifdef FRAC_LUT_CFG_READBACK_EN
      r_rd_valid <= 1'b0;
`endif
      // Start has priority over everything, including a word offered in the same cycle.
      if (cfg.cfg_start) begin
        r_state <= S_LOAD;
        r_cnt   <= '0;
        r_ready <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
`ifdef FRAC_LUT_CFG_READBACK_EN
        r_rd_idx <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg.cfg_valid) r_err <= 1'b1;
          end
          S_LOAD: begin
            if (w_accept) begin
              r_words[r_cnt] <= w_wr_data;
              if (w_last) begin
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_DONE: begin
            if (cfg.cfg_valid) r_err <= 1'b1;
`ifdef FRAC_LUT_CFG_READBACK_EN
            if (cfg.cfg_rd_req) begin
              r_rd_data  <= r_words[r_rd_idx];
              r_rd_valid <= 1'b1;
              r_rd_idx   <= (r_rd_idx == CNT_W'(N_WORDS - 1)) ? '0 : r_rd_idx + 1'b1;
            end
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_done  = r_done;
  assign cfg.cfg_err   = r_err;
`ifdef FRAC_LUT_CFG_READBACK_EN
  assign cfg.cfg_rd_data  = r_rd_data;
  assign cfg.cfg_rd_valid = r_rd_valid;
`endif

  logic [N_CFG-1:0] w_cfg;
  logic [N_T-1:0]   w_t;
  logic             w_m0;
  logic             w_m1;
  logic [K-1:0]     w_a;
  logic [3:0]       w_lo;
  logic [1:0]       w_mid;

  for (genvar gb = 0; gb < N_CFG; gb++) begin : g_flat
    assign w_cfg[gb] = r_words[gb / CFG_W][gb % CFG_W];
  end

  assign w_t  = w_cfg[N_T-1:0];
  assign w_m0 = w_cfg[N_T];
  assign w_m1 = w_cfg[N_T+1];
  assign w_a  = {in[K-1] | w_m1, in[K-2] | w_m0, in[K-3:0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lo
    assign w_lo[gi] = w_t[{2'(gi), in[K-3:0]}];
  end

  for (genvar gj = 0; gj < 2; gj++) begin : g_mid
    assign w_mid[gj] = w_t[{1'(gj), w_a[K-2], in[K-3:0]}];
  end

  assign lut_lo_out   = w_lo & {4{r_done}};
  assign lut_mid_out  = w_mid & {2{r_done}};
  assign lut_full_out = w_t[w_a] & r_done;

endmodule

// File: tb/tb_frac_lut_cfg.sv
// Directed bench for frac_lut_cfg (K=6, CFG_W=8, nine words per image).
// Readback scenario is built when FRAC_LUT_CFG_READBACK_EN is defined.
module tb_frac_lut_cfg;
  localparam int K     = 6;
  localparam int CFG_W = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [K-1:0] in_v;
  logic [3:0] lo;
  logic [1:0] mid;
  logic       full;
  int n_checks = 0;
  int n_fail   = 0;

  frac_lut_cfg_if #(.CFG_W(CFG_W)) cfg_if ();

  frac_lut_cfg #(.K(K), .CFG_W(CFG_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg          (cfg_if.slave),
    .in           (in_v),
    .lut_lo_out   (lo),
    .lut_mid_out  (mid),
    .lut_full_out (full)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] IMG_PAR  = {8'h00, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [71:0] IMG_MODE = {8'h03, 64'h8000_0000_0000_0000};
  localparam logic [71:0] IMG_ONES = {72{1'b1}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input logic [71:0] words, input int first, input int n);
    for (int w = first; w < first + n; w++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = words[w*8 +: 8];
      tick();
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
  endtask

  task automatic load_words(input logic [71:0] words, input int n);
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    drive_words(words, 0, n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_v    = 6'h3F;
    #12;
    n_checks++;
    if ({cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_values got=%b want=0", {cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid});
    end
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid} !== 10'd0) begin
      n_fail++;
      $display("FAIL unloaded_outputs got=%b want=0", {cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid});
    end
  endtask

  task automatic test_parity();
    in_v = 6'h01;
    load_words(IMG_PAR, 8);
    n_checks++;
    if ({cfg_if.cfg_done, cfg_if.cfg_ready, full} !== 3'b010) begin
      n_fail++;
      $display("FAIL before_last_word done/ready/full got=%b want=010", {cfg_if.cfg_done, cfg_if.cfg_ready, full});
    end
    drive_words(IMG_PAR, 8, 1);
    n_checks++;
    if ({cfg_if.cfg_done, cfg_if.cfg_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL after_last_word done/ready got=%b want=10", {cfg_if.cfg_done, cfg_if.cfg_ready});
    end
    #1;
    n_checks++;
    if ({full, lo, mid} !== {1'b1, 4'hF, 2'b11}) begin
      n_fail++;
      $display("FAIL parity_in01 got=%b want=1111111", {full, lo, mid});
    end
    in_v = 6'h00;
    #1;
    n_checks++;
    if ({full, lo, mid} !== 7'd0) begin
      n_fail++;
      $display("FAIL parity_in00 got=%b want=0", {full, lo, mid});
    end
    in_v = 6'h3E;
    #1;
    n_checks++;
    if ({full, lo, mid} !== 7'd0) begin
      n_fail++;
      $display("FAIL parity_in3E got=%b want=0", {full, lo, mid});
    end
  endtask

  task automatic test_mode();
    load_words(IMG_MODE, 9);
    in_v = 6'h0F;
    #1;
    n_checks++;
    if ({full, lo, mid} !== {1'b1, 4'h8, 2'b10}) begin
      n_fail++;
      $display("FAIL mode_in0F got=%b want=1100010", {full, lo, mid});
    end
    in_v = 6'h2F;
    #1;
    n_checks++;
    if ({full, lo, mid} !== {1'b1, 4'h8, 2'b10}) begin
      n_fail++;
      $display("FAIL mode_in2F got=%b want=1100010", {full, lo, mid});
    end
    in_v = 6'h0E;
    #1;
    n_checks++;
    if ({full, lo, mid} !== 7'd0) begin
      n_fail++;
      $display("FAIL mode_in0E got=%b want=0", {full, lo, mid});
    end
  endtask

  task automatic test_err();
    in_v = 6'h0F;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hFF;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_done, cfg_if.cfg_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL err_in_done err/done/ready got=%b want=110", {cfg_if.cfg_err, cfg_if.cfg_done, cfg_if.cfg_ready});
    end
    tick();
    tick();
    n_checks++;
    if ({cfg_if.cfg_err, full, lo, mid} !== {1'b1, 1'b1, 4'h8, 2'b10}) begin
      n_fail++;
      $display("FAIL err_sticky_cfg_kept got=%b want=11100010", {cfg_if.cfg_err, full, lo, mid});
    end
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_done, cfg_if.cfg_ready, full, lo, mid} !== 10'b0010000000) begin
      n_fail++;
      $display("FAIL start_clears err/done/ready/outs got=%b want=0010000000", {cfg_if.cfg_err, cfg_if.cfg_done, cfg_if.cfg_ready, full, lo, mid});
    end
    drive_words(IMG_MODE, 0, 9);
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_done, full} !== 3'b011) begin
      n_fail++;
      $display("FAIL reload_no_err err/done/full got=%b want=011", {cfg_if.cfg_err, cfg_if.cfg_done, full});
    end
  endtask

  task automatic test_restart();
    load_words(IMG_ONES, 4);
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'h5A;
    tick();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_done, cfg_if.cfg_ready, cfg_if.cfg_err} !== 3'b010) begin
      n_fail++;
      $display("FAIL restart_state done/ready/err got=%b want=010", {cfg_if.cfg_done, cfg_if.cfg_ready, cfg_if.cfg_err});
    end
    drive_words(IMG_PAR, 0, 8);
    n_checks++;
    if (cfg_if.cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_counter done after 8 words got=%b want=0", cfg_if.cfg_done);
    end
    drive_words(IMG_PAR, 8, 1);
    n_checks++;
    if (cfg_if.cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done after 9 words got=%b want=1", cfg_if.cfg_done);
    end
    in_v = 6'h02;
    #1;
    n_checks++;
    if ({full, lo, mid} !== 7'd0) begin
      n_fail++;
      $display("FAIL restart_image_in02 got=%b want=0", {full, lo, mid});
    end
    in_v = 6'h01;
    #1;
    n_checks++;
    if ({full, lo, mid} !== {1'b1, 4'hF, 2'b11}) begin
      n_fail++;
      $display("FAIL restart_image_in01 got=%b want=1111111", {full, lo, mid});
    end
    // start with a word in DONE: start wins, no error flagged
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hFF;
    tick();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_ready, cfg_if.cfg_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL start_valid_in_done err/ready/done got=%b want=010", {cfg_if.cfg_err, cfg_if.cfg_ready, cfg_if.cfg_done});
    end
  endtask

  task automatic test_reset_midload();
    load_words(IMG_PAR, 3);
    in_v = 6'h01;
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid} !== 10'd0) begin
      n_fail++;
      $display("FAIL midload_reset got=%b want=0", {cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, full, lo, mid});
    end
    reset_n = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'h11;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL valid_in_idle err/ready got=%b want=10", {cfg_if.cfg_err, cfg_if.cfg_ready});
    end
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    n_checks++;
    if ({cfg_if.cfg_err, cfg_if.cfg_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_after_idle_err err/ready got=%b want=01", {cfg_if.cfg_err, cfg_if.cfg_ready});
    end
  endtask

`ifdef FRAC_LUT_CFG_READBACK_EN
  task automatic test_readback();
    logic [71:0] img;
    logic [7:0]  exp_w [9];
    img   = {8'hFF, 64'h0123_4567_89AB_CDEF};
    exp_w = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h03};
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start  = 1'b0;
    cfg_if.cfg_rd_req = 1'b1;
    tick();
    cfg_if.cfg_rd_req = 1'b0;
    n_checks++;
    if (cfg_if.cfg_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_req_in_load rd_valid got=%b want=0", cfg_if.cfg_rd_valid);
    end
    drive_words(img, 0, 9);
    in_v = 6'h00;
    #1;
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_image_in00 full got=%b want=1", full);
    end
    cfg_if.cfg_rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({cfg_if.cfg_rd_valid, cfg_if.cfg_rd_data} !== {1'b1, exp_w[i % 9]}) begin
        n_fail++;
        $display("FAIL readback_word%0d got=%b/%h want=1/%h", i, cfg_if.cfg_rd_valid, cfg_if.cfg_rd_data, exp_w[i % 9]);
      end
    end
    cfg_if.cfg_rd_req = 1'b0;
    tick();
    n_checks++;
    if (cfg_if.cfg_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_valid_drop got=%b want=0", cfg_if.cfg_rd_valid);
    end
  endtask
`endif

  initial begin
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
`ifdef FRAC_LUT_CFG_READBACK_EN
    cfg_if.cfg_rd_req = 1'b0;
`endif
    test_reset();
    test_parity();
    test_mode();
    test_err();
    test_restart();
    test_reset_midload();
`ifdef FRAC_LUT_CFG_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
